imem_arbiter: RTL and testbench

Shares the single read port of the instruction memory between two requesters: the IFU fetch path and a secondary 32-bit read requester (LSU / loader). Each requester sees the same enable/busy/ready protocol the memory presents, so neither needs to know the port is shared. A round-robin grant decides which request is issued. A branch broadcast from the BU discards an outstanding fetch response so stale instructions never reach the IFU queue.

---
 rtl/imem_arbiter_pkg.sv | 40 ++++
 rtl/imem_arbiter_rr_arbiter2.sv | 48 ++++
 rtl/imem_arbiter.sv | 114 +++++++++++
 tb/tb_imem_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_arbiter_pkg.sv
// ============================================================================
// Module      : imem_arbiter_pkg
// Description : Shared types and constants for the instruction-memory
//               read-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package imem_arbiter_pkg;

    typedef enum logic [2:0] {
        ALU = 3'd0,
        BU  = 3'd1,
        LSU = 3'd2,
        MUL = 3'd3,
        DIV = 3'd4,
        CSR = 3'd5
    } e_functional_unit;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } e_arb_state;

    typedef enum logic [0:0] {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } e_arb_owner;

    // Bit positions of each requester in the req/grant vectors
    localparam int unsigned c_IDX_IFU = 0;
    localparam int unsigned c_IDX_LSU = 1;

    function automatic logic is_flush(input logic valid, input e_functional_unit rs);
        return valid && (rs == BU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/imem_arbiter_rr_arbiter2.sv
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-way round-robin grant; on a tie the requester that was
//               not granted last time wins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter2
    import imem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    // Reset value points at the LSU so the IFU takes the first tie
    logic r_last_lsu;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant[c_IDX_IFU] = 1'b1;
            2'b10:   grant[c_IDX_LSU] = 1'b1;
            2'b11: begin
                if (r_last_lsu) begin
                    grant[c_IDX_IFU] = 1'b1;
                end else begin
                    grant[c_IDX_LSU] = 1'b1;
                end
            end
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_lsu <= 1'b1;
        end else if (advance) begin
            r_last_lsu <= grant[c_IDX_LSU];
        end
    end

endmodule

`default_nettype wire

// File: rtl/imem_arbiter.sv
// ============================================================================
// Module      : imem_arbiter
// Description : Shares the instruction-memory read port between the IFU and
//               a secondary reader; BU broadcasts discard stale fetches.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     bcast_valid_i,
    input  e_functional_unit         bcast_rs_i,

    input  logic [ADDRESS_WIDTH-1:0] ifu_addr_i,
    input  logic                     ifu_en_i,
    output logic [31:0]              ifu_insn_o,
    output logic                     ifu_busy_o,
    output logic                     ifu_rdy_o,

    input  logic [ADDRESS_WIDTH-1:0] lsu_addr_i,
    input  logic                     lsu_en_i,
    output logic [31:0]              lsu_data_o,
    output logic                     lsu_busy_o,
    output logic                     lsu_rdy_o,

    output logic [ADDRESS_WIDTH-1:0] mem_addr_o,
    output logic                     mem_en_o,
    input  logic [31:0]              mem_data_i,
    input  logic                     mem_busy_i,
    input  logic                     mem_rdy_i
);

    e_arb_state r_state;
    e_arb_owner r_owner;
    logic       r_drop;

    logic       w_flush;
    logic       w_idle;
    logic       w_issue;
    logic       w_resp;
    logic [1:0] w_req;
    logic [1:0] w_grant;
    e_arb_owner w_winner;

    assign w_flush  = is_flush(bcast_valid_i, bcast_rs_i);
    assign w_req    = {lsu_en_i, ifu_en_i};
    assign w_winner = w_grant[c_IDX_LSU] ? OWN_LSU : OWN_IFU;

    // rst is folded in so the outputs read idle/busy while reset is held
    assign w_idle  = rst && (r_state == ARB_IDLE);
    assign w_issue = w_idle && !mem_busy_i && (|w_req);
    assign w_resp  = rst && (r_state == ARB_WAIT) && mem_rdy_i;

    rr_arbiter2 u_rr_arbiter2 (
        .clk     (clk),
        .rst     (rst),
        .req     (w_req),
        .advance (w_issue),
        .grant   (w_grant)
    );

    assign mem_en_o   = w_issue;
    assign mem_addr_o = !rst ? '0
                      : (w_winner == OWN_LSU) ? lsu_addr_i : ifu_addr_i;

    assign ifu_busy_o = !(w_issue && w_grant[c_IDX_IFU]);
    assign lsu_busy_o = !(w_issue && w_grant[c_IDX_LSU]);

    // A flush landing on the response cycle suppresses delivery as well
    assign ifu_rdy_o  = w_resp && (r_owner == OWN_IFU) && !r_drop && !w_flush;
    assign lsu_rdy_o  = w_resp && (r_owner == OWN_LSU);

    assign ifu_insn_o = mem_data_i;
    assign lsu_data_o = mem_data_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ARB_IDLE;
            r_owner <= OWN_IFU;
            r_drop  <= 1'b0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_issue) begin
                        r_state <= ARB_WAIT;
                        r_owner <= w_winner;
                        r_drop  <= (w_winner == OWN_IFU) && w_flush;
                    end
                end
                ARB_WAIT: begin
                    if (mem_rdy_i) begin
                        r_state <= ARB_IDLE;
                        r_drop  <= 1'b0;
                    end else if (w_flush && (r_owner == OWN_IFU)) begin
                        r_drop  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                    r_drop  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_imem_arbiter.sv
// ============================================================================
// Module      : tb_imem_arbiter
// Description : Randomized scoreboard bench for imem_arbiter with a
//               transaction-level reference model and memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_arbiter;
    import imem_arbiter_pkg::*;

    localparam int AW = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic             bcast_valid_i;
    e_functional_unit bcast_rs_i;
    logic [AW-1:0]    ifu_addr_i;
    logic             ifu_en_i;
    logic [31:0]      ifu_insn_o;
    logic             ifu_busy_o;
    logic             ifu_rdy_o;
    logic [AW-1:0]    lsu_addr_i;
    logic             lsu_en_i;
    logic [31:0]      lsu_data_o;
    logic             lsu_busy_o;
    logic             lsu_rdy_o;
    logic [AW-1:0]    mem_addr_o;
    logic             mem_en_o;
    logic [31:0]      mem_data_i;
    logic             mem_busy_i;
    logic             mem_rdy_i;

    imem_arbiter #(.ADDRESS_WIDTH(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .bcast_valid_i (bcast_valid_i),
        .bcast_rs_i    (bcast_rs_i),
        .ifu_addr_i    (ifu_addr_i),
        .ifu_en_i      (ifu_en_i),
        .ifu_insn_o    (ifu_insn_o),
        .ifu_busy_o    (ifu_busy_o),
        .ifu_rdy_o     (ifu_rdy_o),
        .lsu_addr_i    (lsu_addr_i),
        .lsu_en_i      (lsu_en_i),
        .lsu_data_o    (lsu_data_o),
        .lsu_busy_o    (lsu_busy_o),
        .lsu_rdy_o     (lsu_rdy_o),
        .mem_addr_o    (mem_addr_o),
        .mem_en_o      (mem_en_o),
        .mem_data_i    (mem_data_i),
        .mem_busy_i    (mem_busy_i),
        .mem_rdy_i     (mem_rdy_i)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Scoreboard queues, filled by the stimulus, drained by the monitor
    logic [AW-1:0] issue_q[$];
    logic [31:0]   ifu_q[$];
    logic [31:0]   lsu_q[$];
    logic [2:0]    ctrl_q[$];
    bit            mon_en = 1'b0;

    // Reference model: pending requests per requester and the one
    // outstanding memory transaction
    bit            ifu_req, lsu_req;
    logic [AW-1:0] ifu_a, lsu_a;
    bit            out_valid;
    int            out_cnt;
    bit            out_lsu;
    bit            out_flushed;
    bit            tie_lsu;
    bit            late_rdy;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic note_fail(input string name, input string what);
        n_cmp++;
        n_err++;
        $display("FAIL %s: %s", name, what);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_mem_en"},   mem_en_o,   0);
        check({tag, "_mem_addr"}, mem_addr_o, 0);
        check({tag, "_ifu_rdy"},  ifu_rdy_o,  0);
        check({tag, "_lsu_rdy"},  lsu_rdy_o,  0);
        check({tag, "_ifu_busy"}, ifu_busy_o, 1);
        check({tag, "_lsu_busy"}, lsu_busy_o, 1);
    endtask

    task automatic step(input bit force_free);
        bit m_rdy, flush, issue, win_lsu;
        m_rdy = 1'b0;
        if (out_valid) begin
            out_cnt--;
            m_rdy = (out_cnt == 0);
        end else if (late_rdy || $urandom_range(0, 15) == 0) begin
            m_rdy = 1'b1;
        end
        late_rdy      = 1'b0;
        mem_rdy_i     = m_rdy;
        mem_data_i    = $urandom;
        mem_busy_i    = force_free ? 1'b0 : ($urandom_range(0, 3) == 0);
        bcast_valid_i = $urandom_range(0, 1) == 1;
        bcast_rs_i    = ($urandom_range(0, 1) == 1) ? BU
                      : e_functional_unit'(3'($urandom_range(0, 5)));
        flush         = bcast_valid_i && (bcast_rs_i == BU);

        if (!ifu_req && $urandom_range(0, 2) == 0) begin
            ifu_req = 1'b1;
            ifu_a   = {$urandom, $urandom};
        end
        if (!lsu_req && $urandom_range(0, 3) == 0) begin
            lsu_req = 1'b1;
            lsu_a   = {$urandom, $urandom};
        end
        ifu_en_i   = ifu_req;
        ifu_addr_i = ifu_req ? ifu_a : {$urandom, $urandom};
        lsu_en_i   = lsu_req;
        lsu_addr_i = lsu_req ? lsu_a : {$urandom, $urandom};

        issue   = 1'b0;
        win_lsu = 1'b0;
        if (out_valid) begin
            // A fetch is delivered only if no flush was seen from issue
            // through response inclusive
            if (flush) out_flushed = 1'b1;
            if (m_rdy) begin
                if (!out_lsu) begin
                    if (!out_flushed) ifu_q.push_back(mem_data_i);
                end else begin
                    lsu_q.push_back(mem_data_i);
                end
                out_valid = 1'b0;
            end
        end else if (!mem_busy_i && (ifu_req || lsu_req)) begin
            issue       = 1'b1;
            win_lsu     = (ifu_req && lsu_req) ? tie_lsu : lsu_req;
            tie_lsu     = !win_lsu;
            issue_q.push_back(win_lsu ? lsu_a : ifu_a);
            out_valid   = 1'b1;
            out_cnt     = $urandom_range(1, 3);
            out_lsu     = win_lsu;
            out_flushed = flush;
            if (win_lsu) lsu_req = 1'b0;
            else         ifu_req = 1'b0;
        end
        ctrl_q.push_back({issue, !(issue && !win_lsu), !(issue && win_lsu)});
    endtask

    logic [2:0] mon_c;

    always @(negedge clk) begin
        if (mon_en && ctrl_q.size() > 0) begin
            mon_c = ctrl_q.pop_front();
            check("en_ifubusy_lsubusy", {mem_en_o, ifu_busy_o, lsu_busy_o}, mon_c);
            if (mem_en_o) begin
                if (issue_q.size() == 0)
                    note_fail("issue_unexpected", $sformatf("got mem_en_o=1 addr %h, required no issue", mem_addr_o));
                else
                    check("mem_addr", mem_addr_o, issue_q.pop_front());
            end
            if (ifu_rdy_o) begin
                if (ifu_q.size() == 0)
                    note_fail("ifu_rdy_unexpected", "got ifu_rdy_o=1, required 0");
                else
                    check("ifu_insn", ifu_insn_o, ifu_q.pop_front());
            end
            if (lsu_rdy_o) begin
                if (lsu_q.size() == 0)
                    note_fail("lsu_rdy_unexpected", "got lsu_rdy_o=1, required 0");
                else
                    check("lsu_data", lsu_data_o, lsu_q.pop_front());
            end
            if (ifu_q.size() != 0) begin
                note_fail("ifu_rdy_missing", "got ifu_rdy_o=0, required 1");
                ifu_q.delete();
            end
            if (lsu_q.size() != 0) begin
                note_fail("lsu_rdy_missing", "got lsu_rdy_o=0, required 1");
                lsu_q.delete();
            end
            issue_q.delete();
        end
    end

    initial begin
        int guard;
        rst           = 1'b0;
        bcast_valid_i = 1'b0;
        bcast_rs_i    = ALU;
        ifu_en_i      = 1'b1;
        lsu_en_i      = 1'b1;
        ifu_addr_i    = 64'h1111_2222_3333_4444;
        lsu_addr_i    = 64'h5555_6666_7777_8888;
        mem_data_i    = 32'hdead_beef;
        mem_busy_i    = 1'b0;
        mem_rdy_i     = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        reset_checks("por");
        ifu_en_i  = 1'b0;
        lsu_en_i  = 1'b0;
        mem_rdy_i = 1'b0;
        #1 rst = 1'b1;

        out_valid = 1'b0;
        tie_lsu   = 1'b0;
        late_rdy  = 1'b0;
        ifu_req   = 1'b1;
        ifu_a     = 64'h40;
        lsu_req   = 1'b1;
        lsu_a     = 64'h1000;
        mon_en    = 1'b1;

        // First cycle after reset: a tie that the IFU must win
        @(posedge clk); #1 step(1'b1);
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1 step(1'b0);
        end

        // Reach a transaction with at least one more waiting cycle
        guard = 0;
        while (!(out_valid && out_cnt >= 2) && guard < 500) begin
            @(posedge clk); #1 step(1'b0);
            guard++;
        end
        if (guard >= 500) note_fail("reach_wait_timeout", "no outstanding transaction within 500 cycles");

        @(posedge clk); #1;
        mon_en = 1'b0;
        ctrl_q.delete();
        issue_q.delete();
        ifu_q.delete();
        lsu_q.delete();
        mem_busy_i = 1'b0;
        mem_rdy_i  = 1'b0;
        ifu_en_i   = 1'b1;
        lsu_en_i   = 1'b1;
        #2 rst = 1'b0;
        mem_rdy_i = 1'b1;
        #1 reset_checks("async_rst");
        @(posedge clk); #1 reset_checks("held_rst");
        ifu_en_i  = 1'b0;
        lsu_en_i  = 1'b0;
        mem_rdy_i = 1'b0;
        #2 rst = 1'b1;

        // Abandon the transaction; the memory still answers it late
        out_valid = 1'b0;
        tie_lsu   = 1'b0;
        late_rdy  = 1'b1;
        mon_en    = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1 step(1'b0);
        end

        // Busy gating while the memory stalls
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            mon_en     = 1'b0;
            ifu_en_i   = 1'b1;
            lsu_en_i   = 1'b1;
            mem_busy_i = 1'b1;
            #1;
            check("membusy_mem_en",   mem_en_o,   0);
            check("membusy_ifu_busy", ifu_busy_o, 1);
            check("membusy_lsu_busy", lsu_busy_o, 1);
        end

        @(negedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
